sram_port_arbiter: RTL and testbench

- Shares the single data-RAM port between instruction fetch (IF) and the EXE-stage load/store path.
- Each side sees a req/addr_ok/data_ok handshake, so IF and EXE can stall with their ready_go signals while the port is busy.
- The RAM side is a plain synchronous SRAM with fixed read latency.
- Sits between the pipeline stages and the RAM model, replacing the direct EXE-to-RAM wiring.

---
 rtl/sram_port_arbiter_pkg.sv | 24 ++
 rtl/sram_arb_grant.sv | 31 +++
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the IF/EXE data-RAM port arbiter: owner, FSM states, latency range.
// Pure definitions, no logic; imported by sram_port_arbiter and sram_arb_grant.
package sram_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 4;
  localparam int CNT_W       = 3;

  function automatic bit ram_lat_legal(input int lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant select between IF and EXE; zero latency, grants only while accept_en is high.
// Fixed data-over-inst priority, or alternation on conflict when ARB_ROUND_ROBIN_EN is defined.
module sram_arb_grant
  import sram_port_arbiter_pkg::*;
(
  input  logic   accept_en,
  input  logic   inst_req,
  input  logic   data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t rr_last,
`endif
  output logic   grant,
  output owner_t winner,
  output logic   inst_addr_ok,
  output logic   data_addr_ok
);

  always_comb begin
    winner = data_req ? OWNER_DATA : OWNER_INST;
`ifdef ARB_ROUND_ROBIN_EN
    // on conflict, serve whichever side lost the previous accept
    if (inst_req && data_req) begin
      winner = (rr_last == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    end
`endif
    grant        = accept_en && (inst_req || data_req);
    inst_addr_ok = grant && (winner == OWNER_INST);
    data_addr_ok = grant && (winner == OWNER_DATA);
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between IF and EXE; data_ok arrives RAM_LATENCY cycles after addr_ok,
// one transaction outstanding, requesters stall on addr_ok. ARB_ROUND_ROBIN_EN enables round-robin grant.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  generate
    if (!ram_lat_legal(RAM_LATENCY)) begin : g_bad_latency
      $error("sram_port_arbiter: RAM_LATENCY must be within 1..4");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  owner_t           owner;
  logic             wr_q;
  logic             accept_en;
  logic             grant;
  owner_t           winner;

  assign accept_en = (state == ST_IDLE) || (state == ST_RESP);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t rr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= OWNER_DATA;
    end else if (grant) begin
      rr_last <= winner;
    end
  end
`endif

  sram_arb_grant u_grant (
    .accept_en    (accept_en),
    .inst_req     (inst_req),
    .data_req     (data_req),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_last      (rr_last),
`endif
    .grant        (grant),
    .winner       (winner),
    .inst_addr_ok (inst_addr_ok),
    .data_addr_ok (data_addr_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // counter holds the cycles left until the RAM word is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      owner <= OWNER_INST;
      wr_q  <= 1'b0;
    end else if (grant) begin
      cnt   <= CNT_W'(RAM_LATENCY);
      owner <= winner;
      wr_q  <= (winner == OWNER_DATA) && data_wr;
    end else if (state == ST_WAIT) begin
      cnt   <= cnt - 1'b1;
    end else if (state == ST_RESP) begin
      cnt   <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (grant) begin
          state_nxt = (RAM_LATENCY > 1) ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(2)) begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en       = grant;
    ram_addr     = (winner == OWNER_DATA) ? data_addr : inst_addr;
    ram_wdata    = (winner == OWNER_DATA) ? data_wdata : 32'h0;
    ram_we       = (grant && (winner == OWNER_DATA) && data_wr) ? data_wstrb : 4'b0000;
    inst_data_ok = (state == ST_RESP) && (owner == OWNER_INST);
    data_data_ok = (state == ST_RESP) && (owner == OWNER_DATA);
    inst_rdata   = ram_rdata;
    // store responses carry no data
    data_rdata   = wr_q ? 32'h0 : ram_rdata;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one DUT at RAM_LATENCY=1 (side a) and one at RAM_LATENCY=3 (side b),
// each with its own SRAM model and response scoreboard.
module tb_sram_port_arbiter;

  localparam int AW = 32;

  typedef struct {
    bit          side;
    bit          chk;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  // ---------------- side a: RAM_LATENCY = 1 ----------------
  logic          a_reset, a_inst_req, a_data_req, a_data_wr;
  logic [AW-1:0] a_inst_addr, a_data_addr, a_ram_addr;
  logic [3:0]    a_data_wstrb, a_ram_we;
  logic [31:0]   a_data_wdata, a_inst_rdata, a_data_rdata, a_ram_wdata, a_ram_rdata;
  logic          a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_ram_en;
  logic [31:0]   mem_a [0:63];
  logic [31:0]   shadow_a [0:63];
  exp_t          exp_a [$];

  sram_port_arbiter #(.RAM_LATENCY(1), .ADDR_W(AW)) dut_a (
    .clk(clk), .reset(a_reset),
    .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_addr_ok(a_inst_addr_ok),
    .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
    .data_req(a_data_req), .data_wr(a_data_wr), .data_wstrb(a_data_wstrb),
    .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_addr_ok(a_data_addr_ok),
    .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  always @(posedge clk) begin
    if (a_reset) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= pat(i);
    end else if (a_ram_en) begin
      a_ram_rdata <= mem_a[a_ram_addr[7:2]];
      for (int j = 0; j < 4; j++)
        if (a_ram_we[j]) mem_a[a_ram_addr[7:2]][8*j +: 8] <= a_ram_wdata[8*j +: 8];
    end
  end

  // ---------------- side b: RAM_LATENCY = 3 ----------------
  logic          b_reset, b_inst_req, b_data_req, b_data_wr;
  logic [AW-1:0] b_inst_addr, b_data_addr, b_ram_addr;
  logic [3:0]    b_data_wstrb, b_ram_we;
  logic [31:0]   b_data_wdata, b_inst_rdata, b_data_rdata, b_ram_wdata, b_ram_rdata;
  logic          b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_ram_en;
  logic [31:0]   mem_b [0:63];
  logic [31:0]   pipe_b [0:2];
  logic [31:0]   shadow_b [0:63];
  exp_t          exp_b [$];

  sram_port_arbiter #(.RAM_LATENCY(3), .ADDR_W(AW)) dut_b (
    .clk(clk), .reset(b_reset),
    .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(b_inst_addr_ok),
    .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
    .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
    .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(b_data_addr_ok),
    .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  assign b_ram_rdata = pipe_b[2];

  always @(posedge clk) begin
    if (b_reset) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= pat(i);
    end else begin
      if (b_ram_en) begin
        pipe_b[0] <= mem_b[b_ram_addr[7:2]];
        for (int j = 0; j < 4; j++)
          if (b_ram_we[j]) mem_b[b_ram_addr[7:2]][8*j +: 8] <= b_ram_wdata[8*j +: 8];
      end
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  // ---------------- scoreboards ----------------
  task automatic monitor_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_reset) begin
        exp_a.delete();
        for (int i = 0; i < 64; i++) shadow_a[i] = pat(i);
      end else begin
        if (a_inst_addr_ok) begin
          e.side = 1'b0; e.chk = 1'b1; e.rdata = shadow_a[a_inst_addr[7:2]]; e.due = cyc + 1;
          exp_a.push_back(e);
        end
        if (a_data_addr_ok) begin
          e.side = 1'b1; e.chk = !a_data_wr; e.rdata = shadow_a[a_data_addr[7:2]]; e.due = cyc + 1;
          if (a_data_wr)
            for (int j = 0; j < 4; j++)
              if (a_data_wstrb[j]) shadow_a[a_data_addr[7:2]][8*j +: 8] = a_data_wdata[8*j +: 8];
          exp_a.push_back(e);
        end
        if (a_inst_data_ok || a_data_data_ok) begin
          n_cmp++;
          if (exp_a.size() == 0) begin
            n_bad++;
            $display("FAIL a_sb_spurious: data_ok {inst,data}=%b at cycle %0d, expected none", {a_inst_data_ok, a_data_data_ok}, cyc);
          end else begin
            e = exp_a.pop_front();
            if ({a_inst_data_ok, a_data_data_ok} !== (e.side ? 2'b01 : 2'b10) || cyc != e.due ||
                (e.chk && (e.side ? a_data_rdata : a_inst_rdata) !== e.rdata)) begin
              n_bad++;
              $display("FAIL a_sb_resp: ok=%b cyc=%0d inst_rdata=%h data_rdata=%h, expected side=%0d cyc=%0d rdata=%h",
                       {a_inst_data_ok, a_data_data_ok}, cyc, a_inst_rdata, a_data_rdata, e.side, e.due, e.rdata);
            end
          end
        end
      end
    end
  endtask

  task automatic monitor_b();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_reset) begin
        exp_b.delete();
        for (int i = 0; i < 64; i++) shadow_b[i] = pat(i);
      end else begin
        if (b_inst_addr_ok) begin
          e.side = 1'b0; e.chk = 1'b1; e.rdata = shadow_b[b_inst_addr[7:2]]; e.due = cyc + 3;
          exp_b.push_back(e);
        end
        if (b_data_addr_ok) begin
          e.side = 1'b1; e.chk = !b_data_wr; e.rdata = shadow_b[b_data_addr[7:2]]; e.due = cyc + 3;
          if (b_data_wr)
            for (int j = 0; j < 4; j++)
              if (b_data_wstrb[j]) shadow_b[b_data_addr[7:2]][8*j +: 8] = b_data_wdata[8*j +: 8];
          exp_b.push_back(e);
        end
        if (b_inst_data_ok || b_data_data_ok) begin
          n_cmp++;
          if (exp_b.size() == 0) begin
            n_bad++;
            $display("FAIL b_sb_spurious: data_ok {inst,data}=%b at cycle %0d, expected none", {b_inst_data_ok, b_data_data_ok}, cyc);
          end else begin
            e = exp_b.pop_front();
            if ({b_inst_data_ok, b_data_data_ok} !== (e.side ? 2'b01 : 2'b10) || cyc != e.due ||
                (e.chk && (e.side ? b_data_rdata : b_inst_rdata) !== e.rdata)) begin
              n_bad++;
              $display("FAIL b_sb_resp: ok=%b cyc=%0d inst_rdata=%h data_rdata=%h, expected side=%0d cyc=%0d rdata=%h",
                       {b_inst_data_ok, b_data_data_ok}, cyc, b_inst_rdata, b_data_rdata, e.side, e.due, e.rdata);
            end
          end
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_ram_en, a_ram_we} !== 9'b0) begin
      n_bad++; $display("FAIL reset_a_outputs: got %b, expected 0", {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_ram_en, a_ram_we});
    end
    n_cmp++;
    if ({b_inst_addr_ok, b_data_addr_ok, b_inst_data_ok, b_data_data_ok, b_ram_en, b_ram_we} !== 9'b0) begin
      n_bad++; $display("FAIL reset_b_outputs: got %b, expected 0", {b_inst_addr_ok, b_data_addr_ok, b_inst_data_ok, b_data_data_ok, b_ram_en, b_ram_we});
    end
    @(posedge clk); #1 a_reset = 1'b0; b_reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({a_inst_data_ok, a_data_data_ok, a_ram_en, b_inst_data_ok, b_data_data_ok, b_ram_en} !== 6'b0) begin
        n_bad++; $display("FAIL reset_idle: got %b, expected 0", {a_inst_data_ok, a_data_data_ok, a_ram_en, b_inst_data_ok, b_data_data_ok, b_ram_en});
      end
    end
  endtask

  task automatic test_inst_read();
    @(posedge clk); #1 a_inst_req = 1'b1; a_inst_addr = 32'h0000_0010;
    @(negedge clk);
    n_cmp++;
    if ({a_inst_addr_ok, a_data_addr_ok, a_ram_en, a_ram_we} !== 7'b1010000 || a_ram_addr !== 32'h10) begin
      n_bad++; $display("FAIL inst_accept: ok/en/we=%b addr=%h, expected 1010000 addr=00000010", {a_inst_addr_ok, a_data_addr_ok, a_ram_en, a_ram_we}, a_ram_addr);
    end
    @(posedge clk); #1 a_inst_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== pat(4) || a_ram_en !== 1'b0) begin
      n_bad++; $display("FAIL inst_resp: data_ok=%b rdata=%h en=%b, expected 1 %h 0", a_inst_data_ok, a_inst_rdata, a_ram_en, pat(4));
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_contention();
    @(posedge clk); #1
    a_inst_req = 1'b1; a_inst_addr = 32'h14;
    a_data_req = 1'b1; a_data_wr = 1'b1; a_data_addr = 32'h20; a_data_wstrb = 4'b0100; a_data_wdata = 32'h00AB_0000;
    @(negedge clk);
    n_cmp++;
    if ({a_inst_addr_ok, a_data_addr_ok, a_ram_we} !== 6'b01_0100 || a_ram_wdata !== 32'h00AB_0000 || a_ram_addr !== 32'h20) begin
      n_bad++; $display("FAIL contention_grant: ok/we=%b wdata=%h addr=%h, expected 010100 00ab0000 00000020", {a_inst_addr_ok, a_data_addr_ok, a_ram_we}, a_ram_wdata, a_ram_addr);
    end
    @(posedge clk); #1 a_data_req = 1'b0; a_data_wr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_data_data_ok, a_inst_addr_ok, a_ram_we} !== 6'b11_0000 || a_ram_addr !== 32'h14) begin
      n_bad++; $display("FAIL contention_retry: dok/iok/we=%b addr=%h, expected 110000 00000014", {a_data_data_ok, a_inst_addr_ok, a_ram_we}, a_ram_addr);
    end
    @(posedge clk); #1 a_inst_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== pat(5)) begin
      n_bad++; $display("FAIL contention_inst_resp: data_ok=%b rdata=%h, expected 1 %h", a_inst_data_ok, a_inst_rdata, pat(5));
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] merged;
    merged = (pat(8) & 32'hFF00_FFFF) | 32'h00AB_0000;
    @(posedge clk); #1
    a_data_req = 1'b1; a_data_wr = 1'b1; a_data_addr = 32'h24; a_data_wstrb = 4'b1111; a_data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (a_data_addr_ok !== 1'b1 || a_ram_we !== 4'b1111) begin
      n_bad++; $display("FAIL b2b_store: addr_ok=%b we=%b, expected 1 1111", a_data_addr_ok, a_ram_we);
    end
    @(posedge clk); #1 a_data_wr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_data_data_ok, a_data_addr_ok, a_ram_en, a_ram_we} !== 7'b1110000) begin
      n_bad++; $display("FAIL b2b_load_accept: dok/aok/en/we=%b, expected 1110000", {a_data_data_ok, a_data_addr_ok, a_ram_en, a_ram_we});
    end
    @(posedge clk); #1 a_data_addr = 32'h20;
    @(negedge clk);
    n_cmp++;
    if (a_data_data_ok !== 1'b1 || a_data_rdata !== 32'hDEAD_BEEF || a_data_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL b2b_load_data: dok=%b rdata=%h aok=%b, expected 1 deadbeef 1", a_data_data_ok, a_data_rdata, a_data_addr_ok);
    end
    @(posedge clk); #1 a_data_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_data_data_ok !== 1'b1 || a_data_rdata !== merged) begin
      n_bad++; $display("FAIL b2b_byte_store: dok=%b rdata=%h, expected 1 %h", a_data_data_ok, a_data_rdata, merged);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_alternation();
    logic exp_data;
    @(posedge clk); #1 a_inst_req = 1'b1; a_inst_addr = 32'h34;
    @(negedge clk);
    n_cmp++;
    if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL alt_lone_inst: {iok,dok}=%b, expected 10", {a_inst_addr_ok, a_data_addr_ok});
    end
    @(posedge clk); #1 a_data_req = 1'b1; a_data_wr = 1'b0; a_data_addr = 32'h30;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      n_cmp++;
      if ({a_inst_addr_ok, a_data_addr_ok} !== {!exp_data, exp_data}) begin
        n_bad++; $display("FAIL alt_grant_%0d: {iok,dok}=%b, expected %b", k, {a_inst_addr_ok, a_data_addr_ok}, {!exp_data, exp_data});
      end
    end
    @(posedge clk); #1 a_inst_req = 1'b0; a_data_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_lat3_stream();
    @(posedge clk); #1 b_data_req = 1'b1; b_data_wr = 1'b0; b_data_addr = 32'h40; b_data_wstrb = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_data_addr_ok, b_ram_en, b_data_data_ok} !== {(k % 3 == 0) && (k <= 6), (k % 3 == 0) && (k <= 6), (k % 3 == 0) && (k >= 3)}) begin
        n_bad++; $display("FAIL lat3_step_%0d: aok/en/dok=%b, expected %b", k, {b_data_addr_ok, b_ram_en, b_data_data_ok},
                          {(k % 3 == 0) && (k <= 6), (k % 3 == 0) && (k <= 6), (k % 3 == 0) && (k >= 3)});
      end
      if (k == 6) begin
        @(posedge clk); #1 b_data_req = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int n_dok;
    int n_iok;
    n_dok = 0;
    n_iok = 0;
    @(posedge clk); #1 b_data_req = 1'b1; b_data_wr = 1'b0; b_data_addr = 32'h44;
    @(negedge clk);
    n_cmp++;
    if (b_data_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_accept: addr_ok=%b, expected 1", b_data_addr_ok);
    end
    @(posedge clk); #1 b_data_req = 1'b0; b_reset = 1'b1;
    @(negedge clk);
    if (b_data_data_ok) n_dok++;
    @(posedge clk); #1 b_reset = 1'b0;
    @(negedge clk);
    if (b_data_data_ok) n_dok++;
    @(posedge clk); #1 b_inst_req = 1'b1; b_inst_addr = 32'h48;
    @(negedge clk);
    if (b_data_data_ok) n_dok++;
    n_cmp++;
    if (b_inst_addr_ok !== 1'b1 || b_ram_addr !== 32'h48) begin
      n_bad++; $display("FAIL rstmid_new_accept: addr_ok=%b addr=%h, expected 1 00000048", b_inst_addr_ok, b_ram_addr);
    end
    @(posedge clk); #1 b_inst_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b_data_data_ok) n_dok++;
      if (b_inst_data_ok) n_iok++;
    end
    n_cmp++;
    if (n_dok != 0 || n_iok != 1) begin
      n_bad++; $display("FAIL rstmid_responses: data_ok count=%0d inst_ok count=%0d, expected 0 and 1", n_dok, n_iok);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_inst_req = 1'b0; a_inst_addr = '0; a_data_req = 1'b0; a_data_wr = 1'b0;
    a_data_wstrb = 4'b0; a_data_addr = '0; a_data_wdata = '0;
    b_reset = 1'b1; b_inst_req = 1'b0; b_inst_addr = '0; b_data_req = 1'b0; b_data_wr = 1'b0;
    b_data_wstrb = 4'b0; b_data_addr = '0; b_data_wdata = '0;
    fork
      monitor_a();
      monitor_b();
    join_none
    test_reset();
    test_inst_read();
    test_contention();
    test_back_to_back();
    test_alternation();
    test_lat3_stream();
    test_reset_mid();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_bad++; $display("FAIL drain: pending a=%0d b=%0d, expected 0 and 0", exp_a.size(), exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
